sdram_wr_feeder: RTL and testbench
==================================

Name: sdram_wr_feeder

Overview:
Upstream write stage for mdy_sdram. It accepts a streaming 16-bit write-data source and buffers it in a small FIFO. It generates sequential SDRAM word addresses from a configured start address and length, and drives the controller's wr_req/waddr/wdata interface, holding each request until wr_ack. It decouples bursty producers (camera, UART, test generator) from SDRAM refresh/init stalls.

Parameters:
DATA_W, 16, write data width; matches the controller wdata.
ADDR_W, 22, word address width; bank[21:20], row[19:8], col[7:0] as the controller decodes it.
FIFO_DEPTH, 16, buffer depth in words; power of two, at least 2.
CNT_W, 5, FIFO occupancy counter width; equals log2(FIFO_DEPTH)+1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse that launches a transfer; ignored unless the state is IDLE.
cfg_addr  in  ADDR_W  first word address; sampled on an accepted start.
cfg_len  in  ADDR_W  number of words to write; sampled on an accepted start.
din  in  DATA_W  input data word.
din_vld  in  1  din is valid this cycle.
din_rdy  out  1  FIFO can accept a word; equals ~fifo_full.
wr_req  out  1  write request to mdy_sdram.
waddr  out  ADDR_W  write address; registered.
wdata  out  DATA_W  write data; registered.
wr_ack  in  1  one-cycle acknowledge from mdy_sdram.
busy  out  1  high from the accepted start until done.
done  out  1  one-cycle pulse at the end of a transfer.
overflow  out  1  sticky flag: din_vld was asserted while the FIFO was full.
fifo_cnt  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; all outputs 0; FIFO pointers and occupancy 0; overflow cleared. A reset mid-transfer abandons it: no done pulse, and buffered data is discarded.
- FIFO:
  - A write occurs when din_vld & din_rdy. din is accepted in any state, so data may be pre-loaded before start.
  - A read (pop) occurs only on wr_ack while in REQ.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - din_vld while full: the word is dropped, FIFO state is unchanged, and overflow is set to 1 on the next cycle. overflow clears only on an accepted start or on reset.
- State machine:
  - IDLE: on start, latch cur_addr=cfg_addr and remain=cfg_len, and set busy=1. If cfg_len==0 go to DONE, otherwise go to LOAD.
  - LOAD: if fifo_cnt!=0, register waddr<=cur_addr and wdata<=FIFO head, set wr_req<=1, and go to REQ. Otherwise stay in LOAD with wr_req=0.
  - REQ: wr_req, waddr and wdata are held stable until wr_ack is sampled high. On wr_ack:
    - pop the FIFO;
    - cur_addr<=cur_addr+1, wrapping modulo 2^ADDR_W (e.g. 0x3FFFFF -> 0x000000);
    - remain<=remain-1;
    - drop wr_req to 0 on the next edge;
    - go to DONE if remain==1, otherwise go to LOAD.
  - DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Timing and sequencing:
  - Minimum throughput is one word per 2 cycles beyond the controller's ack latency (REQ->LOAD->REQ).
  - wr_req never re-asserts in the cycle that follows wr_ack.
  - wr_ack outside REQ is ignored: no pop and no address change.
  - start while busy is ignored and does not alter cfg sampling.
  - Words left in the FIFO after done stay buffered for the next transfer.
- Width rules:
  - remain is ADDR_W bits and unsigned; cfg_len=2^ADDR_W-1 is legal.
  - fifo_cnt ranges 0..FIFO_DEPTH; full means fifo_cnt==FIFO_DEPTH.

Test Plan:
- Pre-load 4 words 0xA001..0xA004, then start with cfg_addr=0x000100, cfg_len=4, and wr_ack one cycle after each wr_req rise -> four requests with waddr 0x100..0x103 carrying matching wdata, done pulses once, fifo_cnt=0, busy low afterwards.
- Start with cfg_len=0 -> wr_req never asserts, done pulses exactly one cycle after start.
- Start with cfg_len=3 and an empty FIFO, then feed words 50 cycles later -> wr_req stays 0 until the first push; it rises the cycle after fifo_cnt becomes 1, then the sequence completes normally.
- Hold wr_ack low for 200 cycles (controller stalled in refresh) -> wr_req, waddr and wdata stay constant across all 200 cycles; a single ack advances exactly one word.
- Push 17 words into a 16-deep FIFO with no transfer active -> din_rdy=0 at fifo_cnt=16, the 17th word is dropped, overflow=1; a subsequent start clears overflow.
- Start with cfg_addr=0x3FFFFE, cfg_len=3; separately, assert rst mid-transfer -> addresses go 0x3FFFFE, 0x3FFFFF, 0x000000; after the reset, all outputs are 0 and there is no done pulse.

Source files
------------

// File: rtl/sdram_wr_feeder.sv
// Write-side feeder for mdy_sdram: buffers a 16-bit stream in a small FIFO and
// issues sequential wr_req/waddr/wdata requests, holding each one until wr_ack.
module sdram_wr_feeder #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 22,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [ADDR_W-1:0] cfg_len,
   input  logic [DATA_W-1:0] din,
   input  logic              din_vld,
   output logic              din_rdy,
   output logic              wr_req,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic              wr_ack,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [CNT_W-1:0]  fifo_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, REQ, DONE} state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wp, r_rp;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_cur, r_remain, r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wr_req, r_busy, r_done, r_ovf;

   logic w_full, w_push, w_pop, w_start_ok;

   assign w_full     = (r_cnt == CNT_W'(FIFO_DEPTH));
   assign w_push     = din_vld & ~w_full;
   assign w_pop      = (r_state == REQ) & wr_ack;
   assign w_start_ok = start & (r_state == IDLE);

   assign din_rdy  = ~w_full;
   assign wr_req   = r_wr_req;
   assign waddr    = r_waddr;
   assign wdata    = r_wdata;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;
   assign fifo_cnt = r_cnt;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         // A drop in the same cycle as an accepted start still flags overflow
         if (din_vld & w_full)
            r_ovf <= 1'b1;
         else if (w_start_ok)
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cur    <= '0;
         r_remain <= '0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_wr_req <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_cur    <= cfg_addr;
                  r_remain <= cfg_len;
                  if (cfg_len == '0) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (r_cnt != '0) begin
                  r_waddr  <= r_cur;
                  r_wdata  <= r_mem[r_rp];
                  r_wr_req <= 1'b1;
                  r_state  <= REQ;
               end
            end
            REQ: begin
               if (wr_ack) begin
                  r_wr_req <= 1'b0;
                  r_cur    <= r_cur + 1'b1;
                  r_remain <= r_remain - 1'b1;
                  if (r_remain == ADDR_W'(1)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= LOAD;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// Scoreboard bench for sdram_wr_feeder: pushed words and start configs queue
// the expected (waddr, wdata) pairs, checked as each request appears.
module tb_sdram_wr_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [21:0] cfg_addr = '0;
   logic [21:0] cfg_len = '0;
   logic [15:0] din = '0;
   logic        din_vld = 1'b0;
   logic        din_rdy;
   logic        wr_req;
   logic [21:0] waddr;
   logic [15:0] wdata;
   logic        wr_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [4:0]  fifo_cnt;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;
   int model_cnt = 0;
   logic [21:0] q_addr[$];
   logic [15:0] q_data[$];

   sdram_wr_feeder #(
      .DATA_W(16), .ADDR_W(22), .FIFO_DEPTH(16), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
      .din(din), .din_vld(din_vld), .din_rdy(din_rdy), .wr_req(wr_req),
      .waddr(waddr), .wdata(wdata), .wr_ack(wr_ack), .busy(busy), .done(done),
      .overflow(overflow), .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] d);
      din = d;
      din_vld = 1'b1;
      if (model_cnt < 16) begin
         q_data.push_back(d);
         model_cnt++;
      end
      tick();
      din_vld = 1'b0;
   endtask

   task automatic do_start(input logic [21:0] a, input logic [21:0] len);
      logic [21:0] ea;
      cfg_addr = a;
      cfg_len  = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
         ea = a + 22'(i);
         q_addr.push_back(ea);
      end
   endtask

   task automatic serve(input int stall);
      logic [21:0] ea;
      logic [15:0] ed;
      int n;
      bit bad;
      n = 0;
      while (wr_req !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (wr_req !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout: wr_req=%b after %0d cycles, required 1", wr_req, n);
         return;
      end
      checks++;
      if (q_addr.size() == 0 || q_data.size() == 0) begin
         errors++;
         $display("FAIL unexpected_req: waddr=%h wdata=%h, no request expected", waddr, wdata);
         return;
      end
      ea = q_addr.pop_front();
      ed = q_data.pop_front();
      model_cnt--;
      checks++;
      if (waddr !== ea) begin
         errors++;
         $display("FAIL waddr: got %h, required %h", waddr, ea);
      end
      checks++;
      if (wdata !== ed) begin
         errors++;
         $display("FAIL wdata: got %h, required %h", wdata, ed);
      end
      if (stall > 0) begin
         bad = 0;
         repeat (stall) begin
            tick();
            if (wr_req !== 1'b1 || waddr !== ea || wdata !== ed) bad = 1;
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL stall_hold: req=%b waddr=%h wdata=%h, required 1 %h %h", wr_req, waddr, wdata, ea, ed);
         end
      end
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      checks++;
      if (wr_req !== 1'b0) begin
         errors++;
         $display("FAIL req_drop: wr_req=%b after ack, required 0", wr_req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({wr_req, waddr, wdata, busy, done, overflow, fifo_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outs: req=%b waddr=%h wdata=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
                  wr_req, waddr, wdata, busy, done, overflow, fifo_cnt);
      end
      checks++;
      if (din_rdy !== 1'b1) begin
         errors++;
         $display("FAIL reset_rdy: din_rdy=%b, required 1", din_rdy);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int d0;
      for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i));
      checks++;
      if (fifo_cnt !== 5'd4) begin
         errors++;
         $display("FAIL preload_cnt: fifo_cnt=%0d, required 4", fifo_cnt);
      end
      d0 = done_seen;
      do_start(22'h000100, 22'd4);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_start: busy=%b, required 1", busy);
      end
      for (int i = 0; i < 4; i++) serve(0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done=%b busy=%b, required 1 0", done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || fifo_cnt !== 5'd0 || busy !== 1'b0 || done_seen - d0 != 1) begin
         errors++;
         $display("FAIL basic_end: done=%b cnt=%0d busy=%b pulses=%0d, required 0 0 0 1",
                  done, fifo_cnt, busy, done_seen - d0);
      end
   endtask

   task automatic test_len0();
      int d0;
      d0 = done_seen;
      do_start(22'h000040, 22'd0);
      checks++;
      if (done !== 1'b1 || wr_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL len0_done: done=%b req=%b busy=%b, required 1 0 0", done, wr_req, busy);
      end
      tick();
      tick();
      checks++;
      if (done !== 1'b0 || wr_req !== 1'b0 || done_seen - d0 != 1) begin
         errors++;
         $display("FAIL len0_end: done=%b req=%b pulses=%0d, required 0 0 1", done, wr_req, done_seen - d0);
      end
   endtask

   task automatic test_late_data();
      bit bad;
      do_start(22'h000500, 22'd3);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         start    = (i == 10);
         cfg_addr = 22'h0003AB;
         cfg_len  = 22'd7;
         tick();
         if (wr_req !== 1'b0) bad = 1;
      end
      start = 1'b0;
      checks++;
      if (bad || busy !== 1'b1) begin
         errors++;
         $display("FAIL late_idle: premature wr_req=%b busy=%b, required 0 1", bad, busy);
      end
      push_word(16'h5001);
      checks++;
      if (fifo_cnt !== 5'd1 || wr_req !== 1'b0) begin
         errors++;
         $display("FAIL late_push: cnt=%0d req=%b, required 1 0", fifo_cnt, wr_req);
      end
      tick();
      checks++;
      if (wr_req !== 1'b1) begin
         errors++;
         $display("FAIL late_rise: wr_req=%b, required 1", wr_req);
      end
      push_word(16'h5002);
      push_word(16'h5003);
      for (int i = 0; i < 3; i++) serve(0);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL late_done: done=%b, required 1", done);
      end
      tick();
   endtask

   task automatic test_stall();
      push_word(16'h7711);
      push_word(16'h7722);
      do_start(22'h000200, 22'd2);
      serve(200);
      checks++;
      if (fifo_cnt !== 5'd1) begin
         errors++;
         $display("FAIL stall_pop: fifo_cnt=%0d, required 1", fifo_cnt);
      end
      serve(0);
      tick();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) push_word(16'hC000 + 16'(i));
      checks++;
      if (fifo_cnt !== 5'd16 || din_rdy !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full: cnt=%0d rdy=%b ovf=%b, required 16 0 0", fifo_cnt, din_rdy, overflow);
      end
      push_word(16'hDEAD);
      checks++;
      if (overflow !== 1'b1 || fifo_cnt !== 5'd16) begin
         errors++;
         $display("FAIL ovf_set: ovf=%b cnt=%0d, required 1 16", overflow, fifo_cnt);
      end
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      checks++;
      if (fifo_cnt !== 5'd16 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL stray_ack: cnt=%0d ovf=%b, required 16 1", fifo_cnt, overflow);
      end
      do_start(22'h000300, 22'd16);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
      end
      for (int i = 0; i < 16; i++) serve(0);
      tick();
   endtask

   task automatic test_wrap_reset();
      int d0;
      for (int i = 0; i < 3; i++) push_word(16'hE000 + 16'(i));
      do_start(22'h3FFFFE, 22'd3);
      for (int i = 0; i < 3; i++) serve(0);
      tick();
      push_word(16'hF001);
      push_word(16'hF002);
      do_start(22'h000010, 22'd5);
      serve(0);
      tick();
      d0 = done_seen;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({wr_req, waddr, wdata, busy, done, overflow, fifo_cnt} !== '0) begin
         errors++;
         $display("FAIL midreset_outs: req=%b waddr=%h wdata=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
                  wr_req, waddr, wdata, busy, done, overflow, fifo_cnt);
      end
      q_addr.delete();
      q_data.delete();
      model_cnt = 0;
      tick();
      rst = 1'b0;
      repeat (4) tick();
      checks++;
      if (done_seen != d0 || busy !== 1'b0 || wr_req !== 1'b0 || fifo_cnt !== 5'd0) begin
         errors++;
         $display("FAIL midreset_after: pulses=%0d busy=%b req=%b cnt=%0d, required 0 0 0 0",
                  done_seen - d0, busy, wr_req, fifo_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len0();
      test_late_data();
      test_stall();
      test_overflow();
      test_wrap_reset();
      checks++;
      if (q_addr.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d requests never seen, required 0", q_addr.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
